// File: rtl/stack_sequencer.sv
// Return-address stack controller: two requesters (CPU, IRQ) share an 8-entry stack
// through a fixed IDLE -> EXEC -> RESP handshake with IRQ priority and a CPU starvation guard.
module stack_sequencer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CpuReq,
    input  logic              CpuOp,
    input  logic [DATA_W-1:0] CpuData,
    output logic              CpuAck,
    input  logic              IrqReq,
    input  logic              IrqOp,
    input  logic [DATA_W-1:0] IrqData,
    output logic              IrqAck,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic [PTR_W-1:0]  SP,
    output logic [PTR_W:0]    Count,
    output logic              Full,
    output logic              Empty,
    output logic              Err,
    output logic [1:0]        ErrCode,
    input  logic              ErrClr
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_OVF = 2'b01, ERR_UDF = 2'b10} err_t;

    state_t              state_q;
    err_t                err_code_q;
    logic                owner_irq_q;
    logic                op_q;
    logic [DATA_W-1:0]   data_q;
    logic [PTR_W:0]      count_q;
    logic [1:0]          starve_q;
    logic                err_q;
    logic                cpu_ack_q;
    logic                irq_ack_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                full;
    logic                empty;
    logic                grant_cpu;
    logic [PTR_W-1:0]    top_idx;

    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign top_idx   = count_q[PTR_W-1:0] - PTR_W'(1);
    // CPU wins only when IRQ is idle or IRQ has already taken two contested grants in a row
    assign grant_cpu = CpuReq && (!IrqReq || (starve_q == 2'd2));

    // Storage is deliberately not reset; a failed push never writes.
    always_ff @(posedge Clk) begin
        if (!Reset && (state_q == S_EXEC) && !op_q && !full) begin
            mem_q[count_q[PTR_W-1:0]] <= data_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            err_code_q  <= ERR_NONE;
            owner_irq_q <= 1'b0;
            op_q        <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            irq_ack_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            cpu_ack_q  <= 1'b0;
            irq_ack_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            // A new error raised in EXEC below overrides this clear.
            if (ErrClr) begin
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end
            case (state_q)
                S_IDLE: begin
                    if (CpuReq || IrqReq) begin
                        owner_irq_q <= !grant_cpu;
                        op_q        <= grant_cpu ? CpuOp : IrqOp;
                        data_q      <= grant_cpu ? CpuData : IrqData;
                        state_q     <= S_EXEC;
                        if (grant_cpu || !CpuReq) starve_q <= '0;
                        else                      starve_q <= starve_q + 2'd1;
                    end
                end
                S_EXEC: begin
                    if (!op_q) begin
                        if (full) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_OVF;
                        end else begin
                            count_q <= count_q + (PTR_W+1)'(1);
                        end
                    end else begin
                        if (empty) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_UDF;
                        end else begin
                            rd_data_q <= mem_q[top_idx];
                            count_q   <= count_q - (PTR_W+1)'(1);
                        end
                    end
                    cpu_ack_q  <= !owner_irq_q;
                    irq_ack_q  <= owner_irq_q;
                    rd_valid_q <= op_q && !empty;
                    state_q    <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CpuAck  = cpu_ack_q;
    assign IrqAck  = irq_ack_q;
    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
    assign Count   = count_q;
    assign SP      = empty ? '0 : top_idx;
    assign Full    = full;
    assign Empty   = empty;
    assign Err     = err_q;
    assign ErrCode = err_code_q;

endmodule
